mc_controller: RTL and testbench

Multicycle successor to the single-cycle ARM control unit. A main FSM sequences each instruction over 3–5 cycles (fetch, decode, execute/memory, writeback) and drives the shared-ALU multicycle datapath. It contains a registered condition-check unit and a parametrised ALU decoder. It sits between the instruction register (Instr) and the multicycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 79 +++++++
 rtl/mc_controller_condlogic.sv | 57 +++++
 rtl/mc_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and constants for the multicycle ARM controller
// Purpose: state encoding, condition codes, ALU command/control codes,
//          datapath mux-select values and the condition-evaluation helper.
// Ports:   none (package).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ILLEGAL  = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // 3-bit ALU control codes; the low two bits are the 2-bit codes.
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_ORR = 3'b011;
  localparam logic [2:0] ALUC_EOR = 3'b100;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // flags = {N,Z,C,V}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = ~z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = ~c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = ~n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = ~v;
      COND_HI: cond_holds = c & ~z;
      COND_LS: cond_holds = ~c | z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = ~z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_condlogic.sv
// rtl/mc_controller_condlogic.sv - flag registers, condition check and write qualification
// Purpose: holds the NZCV flags, evaluates the instruction condition against
//          them, registers the result (CondExD) and gates the write enables.
// Ports:   clk_i, reset_i        clock, synchronous active-high reset
//          cond_i, alu_flags_i   Instr[31:28] and {N,Z,C,V} from the ALU
//          flag_w_i              {NZ write, CV write}
//          pc_update_i, pcs_i    unconditional / conditional PC write requests
//          reg_w_i, no_write_i   register write request and its veto
//          mem_w_i               memory write request
//          pc_write_o, reg_write_o, mem_write_o  qualified enables
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       pc_update_i,
  input  logic       pcs_i,
  input  logic       reg_w_i,
  input  logic       no_write_i,
  input  logic       mem_w_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       cond_ex_q;

  assign cond_ex = cond_holds(cond_i, flags_q);

  always_comb begin
    flags_d = flags_q;
    if (flag_w_i[1] && cond_ex) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] && cond_ex) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex;
    end
  end

  // Writes are masked while reset is held so an aborted instruction cannot
  // commit anything in the reset cycle itself.
  assign pc_write_o  = ~reset_i & (pc_update_i | (pcs_i & cond_ex_q));
  assign reg_write_o = ~reset_i & reg_w_i & cond_ex_q & ~no_write_i;
  assign mem_write_o = ~reset_i & mem_w_i & cond_ex_q;

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM control unit (main FSM, ALU decoder, condition logic)
// Purpose: sequences each instruction over 3-5 cycles and drives the
//          shared-ALU multicycle datapath.
// Config:  MC_CTRL_ILLEGAL_TRAP_EN - Op 11 / unsupported cmd traps in a
//          sticky ILLEGAL state and adds the illegal output.
// Ports:   clk, reset            clock, synchronous active-high reset
//          Instr[19:0]           instruction bits [31:12]
//          ALUFlags              {N,Z,C,V} from the ALU
//          PCWrite, MemWrite, RegWrite, IRWrite  enables
//          AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  mux selects
//          ALUControl            ALU operation (ALU_CTRL_W bits)
//          illegal               (trap build only) high in ILLEGAL
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           Instr,
  input  logic [3:0]            ALUFlags,
  output logic                  PCWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic [1:0]            RegSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal
`endif
);

  // Instr carries bits [31:12], so field positions are offset by 12.
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign i_bit     = Instr[13];
  assign cmd       = Instr[12:9];
  assign s_bit     = Instr[8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_t state_q, state_d;

  logic ir_write, adr_src, pc_update, reg_w, mem_w, branch, alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;

  logic [2:0] alu_ctl;
  logic [1:0] flag_w;
  logic       no_write;
  logic       cmd_ok;
  logic       pcs;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_RN;
    alu_src_b  = SRCB_RM;
    result_src = RES_ALUOUT;
    pc_update  = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_4;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_4;
        result_src = RES_ALURESULT;
        case (op)
          2'b01: state_d = MEMADR;
          2'b00: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!cmd_ok) state_d = ILLEGAL;
            else
`endif
            state_d = i_bit ? EXECUTEI : EXECUTER;
          end
          2'b10: state_d = BRANCH;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = ILLEGAL;
`else
            state_d = FETCH;
`endif
          end
        endcase
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = s_bit ? MEMREAD : MEMWRITE;   // bit 20 is L for memory ops
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECUTER: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRCA_ALUOUT;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch     = 1'b1;
        state_d    = FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ILLEGAL: state_d = ILLEGAL;
`endif
      default: state_d = FETCH;
    endcase
  end

  // ALU decoder. NoWrite is tied to the data-processing class rather than to
  // ALUOp, because the register write happens in ALUWB after ALUOp has
  // dropped; tying it to ALUOp would let CMP/TST write Rd.
  always_comb begin
    alu_ctl  = ALUC_ADD;
    cmd_ok   = 1'b1;
    no_write = 1'b0;
    flag_w   = 2'b00;
    case (cmd)
      CMD_ADD: alu_ctl = ALUC_ADD;
      CMD_SUB: alu_ctl = ALUC_SUB;
      CMD_AND: alu_ctl = ALUC_AND;
      CMD_ORR: alu_ctl = ALUC_ORR;
      CMD_CMP: begin
        alu_ctl  = ALUC_SUB;
        no_write = 1'b1;
      end
      CMD_EOR: begin
        if (ALU_CTRL_W == 3) alu_ctl = ALUC_EOR;
        else                 cmd_ok  = 1'b0;
      end
      CMD_TST: begin
        if (ALU_CTRL_W == 3) begin
          alu_ctl  = ALUC_AND;
          no_write = 1'b1;
        end else begin
          cmd_ok = 1'b0;
        end
      end
      default: cmd_ok = 1'b0;
    endcase
    if (!cmd_ok) begin
      alu_ctl  = ALUC_ADD;
      no_write = 1'b1;
    end
    no_write = no_write & (op == 2'b00);
    if (alu_op && cmd_ok) begin
      flag_w[1] = s_bit;
      flag_w[0] = s_bit & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
    end
    if (!alu_op) alu_ctl = ALUC_ADD;
  end

  assign pcs = branch | (reg_w & (rd == 4'b1111));

  mc_condlogic u_condlogic (
    .clk_i       (clk),
    .reset_i     (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .pc_update_i (pc_update),
    .pcs_i       (pcs),
    .reg_w_i     (reg_w),
    .no_write_i  (no_write),
    .mem_w_i     (mem_w),
    .pc_write_o  (PCWrite),
    .reg_write_o (RegWrite),
    .mem_write_o (MemWrite)
  );

  assign IRWrite    = ir_write & ~reset;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign ALUControl = alu_ctl[ALU_CTRL_W-1:0];

  generate
    if (ALU_CTRL_W < 3) begin : g_narrow_alu
      logic unused_alu_hi;
      assign unused_alu_hi = alu_ctl[2];
    end
  endgenerate

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == ILLEGAL);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [2:0]  w3_ALUControl;
  logic        unused_w3_pcw, unused_w3_mw, unused_w3_rw, unused_w3_irw, unused_w3_adr;
  logic [1:0]  unused_w3_regsrc, unused_w3_srca, unused_w3_srcb, unused_w3_res, unused_w3_imm;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
  logic        unused_w3_illegal;
`endif

  mc_controller #(.ALU_CTRL_W(2)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  mc_controller #(.ALU_CTRL_W(3)) dut3 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(unused_w3_pcw), .MemWrite(unused_w3_mw), .RegWrite(unused_w3_rw),
    .IRWrite(unused_w3_irw), .AdrSrc(unused_w3_adr), .RegSrc(unused_w3_regsrc),
    .ALUSrcA(unused_w3_srca), .ALUSrcB(unused_w3_srcb), .ResultSrc(unused_w3_res),
    .ImmSrc(unused_w3_imm), .ALUControl(w3_ALUControl)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(unused_w3_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle record of one instruction; bit/entry i is cycle i (0 = FETCH).
  int         ncyc;
  logic [7:0] pcw_m, irw_m, mw_m, rw_m, adr_m, ill_m;
  logic [1:0] res_v   [0:7];
  logic [1:0] srca_v  [0:7];
  logic [1:0] srcb_v  [0:7];
  logic [1:0] aluc_v  [0:7];
  logic [2:0] aluc3_v [0:7];

  task automatic sample(input int c);
    pcw_m[c]   = PCWrite;
    irw_m[c]   = IRWrite;
    mw_m[c]    = MemWrite;
    rw_m[c]    = RegWrite;
    adr_m[c]   = AdrSrc;
    res_v[c]   = ResultSrc;
    srca_v[c]  = ALUSrcA;
    srcb_v[c]  = ALUSrcB;
    aluc_v[c]  = ALUControl;
    aluc3_v[c] = w3_ALUControl;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ill_m[c]   = illegal;
`else
    ill_m[c]   = 1'b0;
`endif
  endtask

  // Called one step after a posedge while the DUT is in FETCH. With stop set,
  // returns at the next FETCH (not recorded); max_cyc bounds the wait.
  task automatic run_instr(input logic [31:0] word, input logic [3:0] fl,
                           input int max_cyc, input bit stop);
    Instr    = word[31:12];
    ALUFlags = fl;
    pcw_m = '0; irw_m = '0; mw_m = '0; rw_m = '0; adr_m = '0; ill_m = '0;
    #1;
    sample(0);
    ncyc = 1;
    for (int c = 1; c < max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (stop && IRWrite) break;
      sample(c);
      ncyc = c + 1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;

    // Reset: no writes while reset is high, FETCH outputs right after release.
    #1;
    expect_eq("rst_writes_c0", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      expect_eq("rst_writes", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
    end
    reset = 1'b0;
    #1;
    expect_eq("rst_fetch_irwrite", IRWrite, 1);
    expect_eq("rst_fetch_pcwrite", PCWrite, 1);
    expect_eq("rst_fetch_srcb",    ALUSrcB, 2'b10);

    // ADD r0, r0, r2
    run_instr(32'hE0800002, 4'h0, 8, 1);
    expect_eq("add_cycles",   ncyc, 4);
    expect_eq("add_fetch_res", res_v[0], 2'b10);
    expect_eq("add_aluc",     aluc_v[2], 2'b00);
    expect_eq("add_srca",     srca_v[2], 2'b00);
    expect_eq("add_srcb",     srcb_v[2], 2'b00);
    expect_eq("add_regwrite", rw_m, 8'b0000_1000);
    expect_eq("add_pcwrite",  pcw_m, 8'b0000_0001);

    // CMP r0, #0 with the ALU reporting Z: no register write, Z captured.
    run_instr(32'hE3500000, 4'b0100, 8, 1);
    expect_eq("cmp_cycles",   ncyc, 4);
    expect_eq("cmp_aluc",     aluc_v[2], 2'b01);
    expect_eq("cmp_aluc_w3",  aluc3_v[2], 3'b001);
    expect_eq("cmp_srcb",     srcb_v[2], 2'b01);
    expect_eq("cmp_regwrite", rw_m, 8'b0);

    // BEQ taken (Z=1 stored; ALU flags now 0 to prove the stored copy is used).
    run_instr(32'h0A000000, 4'h0, 8, 1);
    expect_eq("beq_cycles",  ncyc, 3);
    expect_eq("beq_pcwrite", pcw_m, 8'b0000_0101);
    expect_eq("beq_srca",    srca_v[2], 2'b10);

    // BNE not taken.
    run_instr(32'h1A000000, 4'h0, 8, 1);
    expect_eq("bne_cycles",  ncyc, 3);
    expect_eq("bne_pcwrite", pcw_m, 8'b0000_0001);

    // LDR
    run_instr(32'hE5900000, 4'h0, 8, 1);
    expect_eq("ldr_cycles",   ncyc, 5);
    expect_eq("ldr_adrsrc",   adr_m, 8'b0000_1000);
    expect_eq("ldr_res_wb",   res_v[4], 2'b01);
    expect_eq("ldr_regwrite", rw_m, 8'b0001_0000);
    expect_eq("ldr_memwrite", mw_m, 8'b0);
    expect_eq("ldr_immsrc",   ImmSrc, 2'b01);
    expect_eq("ldr_regsrc",   RegSrc, 2'b10);

    // STR
    run_instr(32'hE5800000, 4'h0, 8, 1);
    expect_eq("str_cycles",   ncyc, 4);
    expect_eq("str_memwrite", mw_m, 8'b0000_1000);
    expect_eq("str_regwrite", rw_m, 8'b0);

    // ADDSNE with Z=1: fails, no write, flags must survive (ALU offers 0000).
    run_instr(32'h10900002, 4'h0, 8, 1);
    expect_eq("addne_cycles",   ncyc, 4);
    expect_eq("addne_regwrite", rw_m, 8'b0);
    expect_eq("addne_pcwrite",  pcw_m, 8'b0000_0001);
    run_instr(32'h0A000000, 4'h0, 8, 1);
    expect_eq("beq2_pcwrite", pcw_m, 8'b0000_0101);

    // ADD pc, r0, r2 -> PC written in ALUWB.
    run_instr(32'hE080F002, 4'h0, 8, 1);
    expect_eq("addpc_pcwrite",  pcw_m, 8'b0000_1001);
    expect_eq("addpc_regwrite", rw_m, 8'b0000_1000);

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    // EOR: ADD with no write at width 2, decoded as EOR at width 3.
    run_instr(32'hE0200002, 4'h0, 8, 1);
    expect_eq("eor_cycles",   ncyc, 4);
    expect_eq("eor_aluc_w2",  aluc_v[2], 2'b00);
    expect_eq("eor_aluc_w3",  aluc3_v[2], 3'b100);
    expect_eq("eor_regwrite", rw_m, 8'b0);

    // Op 11 behaves as a NOP: FETCH, DECODE, back to FETCH.
    run_instr(32'hEC000000, 4'h0, 8, 1);
    expect_eq("nop_cycles", ncyc, 2);
    expect_eq("nop_writes", pcw_m | mw_m | rw_m, 8'b0000_0001);
`endif

    // Abort STR in MEMWRITE with reset: strobe masked, flags cleared.
    run_instr(32'hE5800000, 4'h0, 4, 0);
    expect_eq("abort_pre_mw", mw_m, 8'b0000_1000);
    reset = 1'b1;
    #1;
    expect_eq("abort_mw_masked", MemWrite, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    expect_eq("abort_fetch", {IRWrite, MemWrite}, 2'b10);
    run_instr(32'h0A000000, 4'h0, 8, 1);
    expect_eq("abort_beq_pcwrite", pcw_m, 8'b0000_0001);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // Unsupported cmd at width 2 traps; the width-3 copy executes EOR.
    run_instr(32'hE0200002, 4'h0, 6, 0);
    expect_eq("trap_cmd_illegal", ill_m, 8'b0011_1100);
    expect_eq("trap_cmd_enables", (pcw_m | irw_m | mw_m | rw_m) & 8'b0011_1100, 8'b0);
    expect_eq("trap_cmd_aluc_w3", aluc3_v[2], 3'b100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("trap_cleared", illegal, 0);
    reset = 1'b0;
    #1;
    run_instr(32'hEC000000, 4'h0, 5, 0);
    expect_eq("trap_op11_illegal", ill_m, 8'b0001_1100);
    expect_eq("trap_op11_irwrite", irw_m, 8'b0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
